// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin grant arbiter.
package rr_arb_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // OR-encode a one-hot vector into a binary index. The input and output
  // are wide enough for any practical NREQ; callers zero-extend and then
  // slice the result. An all-zero input encodes to 0.
  function automatic logic [7:0] onehot2bin(input logic [255:0] oh);
    logic [7:0] res;
    res = '0;
    for (int i = 0; i < 256; i++)
      if (oh[i]) res = res | 8'(i);
    return res;
  endfunction

endpackage

// File: rtl/lsb_onehot_pick.sv
// Keeps only the lowest set bit of the input vector and clears the rest.
module lsb_onehot_pick #(
  parameter int W = 4
) (
  input  logic [W-1:0] in_i,
  output logic [W-1:0] out_o
);

  // below[i] is set when any bit strictly below i is set
  logic [W-1:0] below;

  assign below[0] = 1'b0;
  assign out_o[0] = in_i[0];

  for (genvar g = 1; g < W; g++) begin : g_bit
    assign below[g] = below[g-1] | in_i[g-1];
    assign out_o[g] = in_i[g] & ~below[g];
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, hold-while-requesting
// and forced rotation after MAXHOLD consecutive cycles.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int MAXHOLD = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  output logic [NREQ-1:0]         grant,
  output logic                    grant_valid,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW = $clog2(NREQ);
  localparam int HW = $clog2(MAXHOLD+1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAXHOLD-1);

  arb_state_t      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [IW-1:0]   last_q, last_d;
  logic [HW-1:0]   hold_q, hold_d;

  logic [NREQ-1:0] cand, hi_mask, pick_m, pick_u, pick;
  logic [IW-1:0]   pick_idx, grant_idx;
  logic [7:0]      pick_bin, grant_bin;
  logic            owner_req;

  // Owner is cleared from the candidates whenever a grant is active: on
  // release its req bit is already 0, on expiry it must be skipped.
  assign cand      = (state_q == ARB_GRANT) ? (req & ~grant_q) : req;
  assign owner_req = |(req & grant_q);

  for (genvar g = 0; g < NREQ; g++) begin : g_mask
    assign hi_mask[g] = (g > int'(last_q));
  end

  lsb_onehot_pick #(.W(NREQ)) u_pick_m (.in_i(cand & hi_mask), .out_o(pick_m));
  lsb_onehot_pick #(.W(NREQ)) u_pick_u (.in_i(cand),           .out_o(pick_u));

  assign pick      = (|pick_m) ? pick_m : pick_u;
  assign pick_bin  = onehot2bin(256'(pick));
  assign pick_idx  = pick_bin[IW-1:0];
  assign grant_bin = onehot2bin(256'(grant_q));
  assign grant_idx = grant_bin[IW-1:0];

  // Next-state: arbitrate from idle, hold, release or expire the current owner
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    hold_d  = hold_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (|req) begin
          grant_d = pick;
          last_d  = pick_idx;
          hold_d  = '0;
          state_d = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (owner_req && (hold_q < HOLD_LAST)) begin
          hold_d = hold_q + 1'b1;
        end else if (|cand) begin
          grant_d = pick;
          last_d  = pick_idx;
          hold_d  = '0;
        end else if (owner_req) begin
          // Expired but nobody else wants it: re-grant without a gap
          hold_d = '0;
        end else begin
          grant_d = '0;
          hold_d  = '0;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
        hold_d  = '0;
      end
    endcase
  end

  // State, grant, last pointer and hold counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= IW'(NREQ-1);
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = grant_idx;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Directed bench for rr_grant_arbiter (NREQ=4, MAXHOLD=4).
module tb_rr_grant_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] grant;
  logic       grant_valid;
  logic [1:0] grant_id;

  int checks   = 0;
  int failures = 0;

  rr_grant_arbiter #(.NREQ(4), .MAXHOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Structural invariants on the current outputs
  task automatic inv();
    logic [1:0] id;
    int n;
    id = '0;
    n = 0;
    for (int i = 0; i < 4; i++)
      if (grant[i]) begin id = id | 2'(i); n++; end
    chk("inv_onehot0", 32'(n <= 1), 32'd1);
    chk("inv_valid",   32'(grant_valid), 32'(grant != 4'b0));
    chk("inv_id",      32'(grant_id), 32'(id));
  endtask

  // Advance one rising edge, then look at the outputs just after it
  task automatic tick();
    @(posedge clk);
    #1;
    inv();
  endtask

  task automatic expect_grant(input string tag, input logic [3:0] g, input logic v, input logic [1:0] id);
    chk({tag, "_grant"}, 32'(grant), 32'(g));
    chk({tag, "_valid"}, 32'(grant_valid), 32'(v));
    chk({tag, "_id"},    32'(grant_id), 32'(id));
  endtask

  initial begin
    logic [3:0] exp_g;

    // 1. reset held, then released with req=0110
    rst = 1'b1;
    req = 4'b0110;
    tick();
    tick();
    expect_grant("t1_reset", 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    tick();
    expect_grant("t1_first", 4'b0010, 1'b1, 2'd1);

    // 2. constant all-request: each owner exactly 4 cycles, no gaps
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    req = 4'b1111;
    for (int k = 0; k < 17; k++) begin
      tick();
      exp_g = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("t2_rr_%0d", k), 32'(grant), 32'(exp_g));
    end

    // 3. owner bit0 drops, bit2 takes over on the same edge
    rst = 1'b1; req = 4'b0000;
    tick();
    rst = 1'b0;
    req = 4'b0101;
    tick();
    expect_grant("t3_own0", 4'b0001, 1'b1, 2'd0);
    req = 4'b0100;
    tick();
    expect_grant("t3_handoff", 4'b0100, 1'b1, 2'd2);

    // non-owner request appearing must not disturb the current owner
    req = 4'b0101;
    tick();
    chk("t3_noniterf", 32'(grant), 32'h4);

    // 4. lone requester 3 keeps the grant across expiries
    req = 4'b1000;
    tick();
    expect_grant("t4_take", 4'b1000, 1'b1, 2'd3);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk($sformatf("t4_hold_%0d", k), 32'({grant_valid, grant}), 32'h18);
    end

    // 5. reset between edges drops outputs immediately
    rst = 1'b1;
    #1;
    expect_grant("t5_async", 4'b0000, 1'b0, 2'd0);
    req = 4'b1111;
    tick();
    expect_grant("t5_held", 4'b0000, 1'b0, 2'd0);
    rst = 1'b0;
    tick();
    expect_grant("t5_restart", 4'b0001, 1'b1, 2'd0);

    // 6. owner drops with no other requester: back to idle
    req = 4'b0000;
    tick();
    expect_grant("t6_idle", 4'b0000, 1'b0, 2'd0);
    tick();
    expect_grant("t6_stay", 4'b0000, 1'b0, 2'd0);

    // from idle with last=0, requester 1 wins over 0 when both ask
    req = 4'b0011;
    tick();
    expect_grant("t6_rr_ptr", 4'b0010, 1'b1, 2'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
